// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle 32x32 -> low-32 multiplier built on top of the core's
// single-cycle ALU. Uses a shift-add loop: one TEST per multiplier bit,
// an ADD when that bit is set, then a SHIFT of multiplicand/multiplier.
// The ALU itself is external; this block only drives its operand/opcode
// inputs and consumes its result and zero flag in the same cycle.
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_operation,
  output logic        alu_invert,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] m_reg;       // multiplicand, shifted left each iteration
  logic [31:0] q_reg;       // remaining multiplier, shifted right each iteration
  logic [31:0] p_reg;       // running partial product
  logic [4:0]  count_reg;   // completed iterations
  logic [31:0] result_reg;

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision and ALU drive; the ALU is idle (AND of zeros)
  // outside TEST and ADD so its outputs are quiet whenever unused.
  always_comb begin
    state_next    = state_reg;
    alu_operation = ALU_AND;
    alu_src1      = 32'd0;
    alu_src2      = 32'd0;
    alu_invert    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = TEST;
        end
      end
      TEST: begin
        // OR with zero passes Q through so the ALU zero flag reports Q==0.
        alu_operation = ALU_OR;
        alu_src1      = q_reg;
        alu_src2      = 32'd0;
        if (EARLY_EXIT && alu_zero) begin
          state_next = DONE;
        end else if (q_reg[0]) begin
          state_next = ADD;
        end else begin
          state_next = SHIFT;
        end
      end
      ADD: begin
        alu_operation = ALU_ADD;
        alu_src1      = p_reg;
        alu_src2      = m_reg;
        state_next    = SHIFT;
      end
      SHIFT: begin
        if (count_reg == 5'd31) begin
          state_next = DONE;
        end else begin
          state_next = TEST;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: operand capture, accumulate, shift, and result
  // publication. The result is written on entry to DONE (P is already final
  // then) so it is valid in the same cycle that done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg      <= 32'd0;
      q_reg      <= 32'd0;
      p_reg      <= 32'd0;
      count_reg  <= 5'd0;
      result_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            m_reg     <= op_a;
            q_reg     <= op_b;
            p_reg     <= 32'd0;
            count_reg <= 5'd0;
          end
        end
        ADD: begin
          p_reg <= alu_out;
        end
        SHIFT: begin
          m_reg     <= m_reg << 1;
          q_reg     <= q_reg >> 1;
          count_reg <= count_reg + 5'd1;
        end
        default: begin
        end
      endcase
      if ((state_next == DONE) && (state_reg != DONE)) begin
        result_reg <= p_reg;
      end
    end
  end

endmodule
